// File: rtl/bmu_issue_ctrl.sv
// BMU initiator: buffers tagged requests, decodes opcodes to the ap control vector,
// issues one op per cycle and returns results in request order with their tags.
module bmu_issue_ctrl #(
    parameter int REQ_DEPTH  = 4,
    parameter int RESP_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             bmu_valid_out,
    output logic [31:0]      bmu_a_out,
    output logic [31:0]      bmu_b_out,
    output logic [22:0]      bmu_ap_out,
    input  logic [31:0]      bmu_result_in,
    input  logic             bmu_error_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_error,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);
    localparam int RQ_AW = $clog2(REQ_DEPTH);
    localparam int RS_AW = $clog2(RESP_DEPTH);
    localparam int RQ_W  = 5 + 32 + 32 + TAG_W;
    localparam int RS_W  = 32 + 1 + TAG_W;
    localparam logic [RQ_AW:0]   RQ_FULL  = (RQ_AW + 1)'(REQ_DEPTH);
    localparam logic [RQ_AW:0]   RQ_ONE   = (RQ_AW + 1)'(1);
    localparam logic [RS_AW:0]   RS_ONE   = (RS_AW + 1)'(1);
    localparam logic [RS_AW+1:0] RS_LIMIT = (RS_AW + 2)'(RESP_DEPTH);

    // ap bit positions, bit22 = csr_write down to bit0 = gorc
    localparam logic [22:0] AP_ZBB   = 23'h100000;
    localparam logic [22:0] AP_LAND  = 23'h010000;
    localparam logic [22:0] AP_LXOR  = 23'h008000;
    localparam logic [22:0] AP_SLL   = 23'h004000;
    localparam logic [22:0] AP_SRA   = 23'h002000;
    localparam logic [22:0] AP_BEXT  = 23'h000800;
    localparam logic [22:0] AP_ADD   = 23'h000200;
    localparam logic [22:0] AP_SLT   = 23'h000100;
    localparam logic [22:0] AP_UNSGN = 23'h000080;
    localparam logic [22:0] AP_SUB   = 23'h000040;
    localparam logic [22:0] AP_CLZ   = 23'h000020;
    localparam logic [22:0] AP_CPOP  = 23'h000010;
    localparam logic [22:0] AP_SEXTH = 23'h000008;
    localparam logic [22:0] AP_MIN   = 23'h000004;
    localparam logic [22:0] AP_PACKU = 23'h000002;
    localparam logic [22:0] AP_GORC  = 23'h000001;

    logic [RQ_W-1:0]  rq_mem [REQ_DEPTH];
    logic [RQ_AW:0]   rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d, rq_cnt;
    logic             rq_empty, rq_push, rq_pop;
    logic [4:0]       head_op;
    logic [31:0]      head_a, head_b;
    logic [TAG_W-1:0] head_tag;

    logic [RS_W-1:0]  rs_mem [RESP_DEPTH];
    logic [RS_AW:0]   rs_wr_q, rs_wr_d, rs_rd_q, rs_rd_d, rs_cnt;
    logic             rs_push, rs_pop;
    logic [RS_W-1:0]  rs_wdata;
    logic [RS_AW+1:0] inflight;

    logic [22:0]      dec_ap;
    logic             dec_ill;

    logic             s1_v_q, s1_ill_q, s2_v_q, s2_ill_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
    logic             bmu_valid_q;
    logic [31:0]      bmu_a_q, bmu_a_d, bmu_b_q, bmu_b_d;
    logic [22:0]      bmu_ap_q, bmu_ap_d;

    assign rq_cnt    = rq_wr_q - rq_rd_q;
    assign rq_empty  = (rq_cnt == '0);
    assign req_ready = rst_l && (rq_cnt != RQ_FULL);
    assign rq_push   = req_valid && req_ready;
    assign {head_op, head_a, head_b, head_tag} = rq_mem[rq_rd_q[RQ_AW-1:0]];

    // Credit counts every op that will eventually land in the response FIFO;
    // a same-cycle response pop is not credited back until the next cycle.
    assign inflight = {1'b0, rs_cnt} + {{(RS_AW + 1){1'b0}}, s1_v_q}
                    + {{(RS_AW + 1){1'b0}}, s2_v_q};
    assign rq_pop   = !rq_empty && (inflight < RS_LIMIT);

    assign rs_cnt   = rs_wr_q - rs_rd_q;
    assign rs_push  = s2_v_q;
    assign rs_wdata = s2_ill_q ? {32'h0, 1'b1, s2_tag_q}
                               : {bmu_result_in, bmu_error_in, s2_tag_q};
    assign resp_valid = (rs_cnt != '0);
    assign rs_pop     = resp_valid && resp_ready;
    assign {resp_result, resp_error, resp_tag} = rs_mem[rs_rd_q[RS_AW-1:0]];

    assign busy = !rq_empty || s1_v_q || s2_v_q || resp_valid;

    assign bmu_valid_out = bmu_valid_q;
    assign bmu_a_out     = bmu_a_q;
    assign bmu_b_out     = bmu_b_q;
    assign bmu_ap_out    = bmu_ap_q;

    always_comb begin
        dec_ap  = '0;
        dec_ill = 1'b0;
        case (head_op)
            5'd0:    dec_ap = AP_ADD;
            5'd1:    dec_ap = AP_SUB;
            5'd2:    dec_ap = AP_LAND;
            5'd3:    dec_ap = AP_LAND | AP_ZBB;
            5'd4:    dec_ap = AP_LXOR;
            5'd5:    dec_ap = AP_SLL;
            5'd6:    dec_ap = AP_SRA;
            5'd7:    dec_ap = AP_BEXT;
            5'd8:    dec_ap = AP_SLT;
            5'd9:    dec_ap = AP_SLT | AP_UNSGN;
            5'd10:   dec_ap = AP_MIN | AP_SUB;
            5'd11:   dec_ap = AP_CLZ;
            5'd12:   dec_ap = AP_CPOP;
            5'd13:   dec_ap = AP_SEXTH;
            5'd14:   dec_ap = AP_PACKU;
            5'd15:   dec_ap = AP_GORC;
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        rq_wr_d  = rq_push ? rq_wr_q + RQ_ONE : rq_wr_q;
        rq_rd_d  = rq_pop  ? rq_rd_q + RQ_ONE : rq_rd_q;
        rs_wr_d  = rs_push ? rs_wr_q + RS_ONE : rs_wr_q;
        rs_rd_d  = rs_pop  ? rs_rd_q + RS_ONE : rs_rd_q;
        bmu_a_d  = bmu_a_q;
        bmu_b_d  = bmu_b_q;
        bmu_ap_d = bmu_ap_q;
        if (rq_pop) begin
            // Illegal ops never reach the BMU, so keep its inputs quiet.
            bmu_a_d  = dec_ill ? 32'h0 : head_a;
            bmu_b_d  = dec_ill ? 32'h0 : head_b;
            bmu_ap_d = dec_ap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rq_wr_q     <= '0;
            rq_rd_q     <= '0;
            rs_wr_q     <= '0;
            rs_rd_q     <= '0;
            s1_v_q      <= 1'b0;
            s1_ill_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_ill_q    <= 1'b0;
            s2_tag_q    <= '0;
            bmu_valid_q <= 1'b0;
            bmu_a_q     <= '0;
            bmu_b_q     <= '0;
            bmu_ap_q    <= '0;
        end else begin
            rq_wr_q     <= rq_wr_d;
            rq_rd_q     <= rq_rd_d;
            rs_wr_q     <= rs_wr_d;
            rs_rd_q     <= rs_rd_d;
            s1_v_q      <= rq_pop;
            if (rq_pop) begin
                s1_ill_q <= dec_ill;
                s1_tag_q <= head_tag;
            end
            s2_v_q      <= s1_v_q;
            s2_ill_q    <= s1_ill_q;
            s2_tag_q    <= s1_tag_q;
            bmu_valid_q <= rq_pop && !dec_ill;
            bmu_a_q     <= bmu_a_d;
            bmu_b_q     <= bmu_b_d;
            bmu_ap_q    <= bmu_ap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rq_push) rq_mem[rq_wr_q[RQ_AW-1:0]] <= {req_op, req_a, req_b, req_tag};
        if (rs_push) rs_mem[rs_wr_q[RS_AW-1:0]] <= rs_wdata;
    end
endmodule

// File: tb/tb_bmu_issue_ctrl.sv
// Directed bench for bmu_issue_ctrl with a behavioural BMU and in-order
// scoreboards for both the BMU issue port and the response port.
module tb_bmu_issue_ctrl;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_l, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [4:0]       req_op;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag, resp_tag;
    logic             bmu_valid_out, resp_error;
    logic [31:0]      bmu_a_out, bmu_b_out, resp_result;
    logic [22:0]      bmu_ap_out;
    logic [31:0]      bmu_result_in = 32'h0;
    logic             bmu_error_in = 1'b0;

    typedef struct packed {logic [31:0] res; logic err; logic [TAG_W-1:0] tag;} resp_t;
    typedef struct packed {logic [22:0] ap; logic [31:0] a; logic [31:0] b;} iss_t;

    resp_t sb_q[$];
    iss_t  iss_q[$];
    int    n_cmp = 0, n_mis = 0, n_resp = 0, n_bmu = 0, cyc = 0;
    int    bmu_cyc_prev = 0, bmu_cyc_last = 0;
    logic  acc_flag = 1'b0, hold_v = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_res = 32'h0;
    resp_t hold_d;

    bmu_issue_ctrl #(.REQ_DEPTH(4), .RESP_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .bmu_valid_out(bmu_valid_out), .bmu_a_out(bmu_a_out), .bmu_b_out(bmu_b_out),
        .bmu_ap_out(bmu_ap_out), .bmu_result_in(bmu_result_in), .bmu_error_in(bmu_error_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_error(resp_error), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] ap_of(input logic [4:0] op);
        case (op)
            5'd0:  return 23'h000200;
            5'd1:  return 23'h000040;
            5'd2:  return 23'h010000;
            5'd3:  return 23'h110000;
            5'd4:  return 23'h008000;
            5'd5:  return 23'h004000;
            5'd6:  return 23'h002000;
            5'd7:  return 23'h000800;
            5'd8:  return 23'h000100;
            5'd9:  return 23'h000180;
            5'd10: return 23'h000044;
            5'd11: return 23'h000020;
            5'd12: return 23'h000010;
            5'd13: return 23'h000008;
            5'd14: return 23'h000002;
            default: return 23'h000001;
        endcase
    endfunction

    // Behavioural BMU: result and error registered one cycle after valid_in.
    function automatic logic [32:0] bmu_model(input logic [22:0] ap, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic e;
        r = 32'h0;
        e = 1'b0;
        if (ap[9]) begin
            r = a + b;
            e = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (ap[2]) r = ($signed(a) < $signed(b)) ? a : b;
        else if (ap[6]) begin
            r = a - b;
            e = (a[31] != b[31]) && (r[31] != a[31]);
        end else if (ap[16]) r = ap[20] ? (a & ~b) : (a & b);
        else if (ap[15]) r = a ^ b;
        else if (ap[14]) r = a << b[4:0];
        else if (ap[13]) r = $signed(a) >>> b[4:0];
        else if (ap[11]) r = {31'h0, a[b[4:0]]};
        else if (ap[8])  r = {31'h0, ap[7] ? (a < b) : ($signed(a) < $signed(b))};
        else if (ap[5]) begin
            r = 32'd32;
            for (int i = 0; i < 32; i++) if (a[i]) r = 32'(31 - i);
        end else if (ap[4]) r = 32'($countones(a));
        else if (ap[3]) r = {{16{a[15]}}, a[15:0]};
        else if (ap[1]) r = {b[31:16], a[31:16]};
        else if (ap[0]) begin
            if (b[4:0] == 5'd7) begin
                for (int k = 0; k < 4; k++) r[8*k +: 8] = (|a[8*k +: 8]) ? 8'hFF : 8'h00;
            end else e = 1'b1;
        end
        return {e, r};
    endfunction

    always @(posedge clk) begin
        if (bmu_valid_out) {bmu_error_in, bmu_result_in} <= bmu_model(bmu_ap_out, bmu_a_out, bmu_b_out);
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: monitor both output ports at the falling edge, then advance.
    task automatic tick();
        resp_t e;
        iss_t  s;
        @(negedge clk);
        cyc++;
        if (hold_v && resp_valid)
            chk("resp_stable", 64'({resp_result, resp_error, resp_tag}), 64'(hold_d));
        hold_v = resp_valid && !resp_ready;
        hold_d = {resp_result, resp_error, resp_tag};
        if (resp_valid && resp_ready) begin
            n_resp++;
            chk("resp_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("resp_result", 64'(resp_result), 64'(e.res));
                chk("resp_error", 64'(resp_error), 64'(e.err));
                chk("resp_tag", 64'(resp_tag), 64'(e.tag));
            end
        end
        if (bmu_valid_out) begin
            n_bmu++;
            bmu_cyc_prev = bmu_cyc_last;
            bmu_cyc_last = cyc;
            chk("bmu_expected", 64'(iss_q.size() != 0), 64'(1));
            if (iss_q.size() != 0) begin
                s = iss_q.pop_front();
                chk("bmu_ap", 64'(bmu_ap_out), 64'(s.ap));
                chk("bmu_a", 64'(bmu_a_out), 64'(s.a));
                chk("bmu_b", 64'(bmu_b_out), 64'(s.b));
            end
        end
        acc_flag = req_valid && req_ready;
        if (acc_flag) begin
            sb_q.push_back({exp_res, exp_err, req_tag});
            if (req_op < 5'd16) iss_q.push_back({ap_of(req_op), req_a, req_b});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic err);
        int c;
        c = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        exp_res = res; exp_err = err;
        do begin
            tick();
            c++;
        end while (!acc_flag && c < 50);
        chk("send_accept", 64'(acc_flag), 64'(1));
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sb_q.size() != 0 || busy) && c < budget) begin
            tick();
            c++;
        end
        chk("drain_in_time", 64'(c < budget), 64'(1));
        chk("drain_sb_empty", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        int k, m, n0;
        rst_l = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        chk("rst_bmu_valid", 64'(bmu_valid_out), 64'(0));
        chk("rst_bmu_a", 64'(bmu_a_out), 64'(0));
        chk("rst_bmu_b", 64'(bmu_b_out), 64'(0));
        chk("rst_bmu_ap", 64'(bmu_ap_out), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst_l = 1'b1;
        tick();
        chk("post_rst_req_ready", 64'(req_ready), 64'(1));

        // ADD 5+7 with exact latency checks
        send(5'd0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
        req_valid = 1'b0;
        tick();
        chk("lat_bmu_valid", 64'(bmu_valid_out), 64'(1));
        chk("lat_bmu_ap", 64'(bmu_ap_out), 64'(23'h000200));
        tick();
        chk("lat_resp_early", 64'(resp_valid), 64'(0));
        tick();
        chk("lat_resp_valid", 64'(resp_valid), 64'(1));
        chk("lat_resp_result", 64'(resp_result), 64'(12));
        chk("lat_resp_tag", 64'(resp_tag), 64'(3));
        drain(20);

        // every legal opcode, back to back
        send(5'd0,  32'h7FFFFFFF, 32'h1,        4'd1,  32'h80000000, 1'b1);
        send(5'd9,  32'h1,        32'hFFFFFFFF, 4'd2,  32'h1,        1'b0);
        send(5'd3,  32'hFF,       32'h0F,       4'd3,  32'hF0,       1'b0);
        send(5'd1,  32'd10,       32'd3,        4'd4,  32'd7,        1'b0);
        send(5'd2,  32'hFF,       32'h0F,       4'd5,  32'h0F,       1'b0);
        send(5'd5,  32'h1,        32'd4,        4'd6,  32'h10,       1'b0);
        send(5'd6,  32'h80000000, 32'd4,        4'd7,  32'hF8000000, 1'b0);
        send(5'd7,  32'h20,       32'd5,        4'd8,  32'h1,        1'b0);
        send(5'd8,  32'hFFFFFFFF, 32'h0,        4'd9,  32'h1,        1'b0);
        send(5'd10, 32'hFFFFFFFE, 32'd5,        4'd10, 32'hFFFFFFFE, 1'b0);
        send(5'd11, 32'h00010000, 32'h0,        4'd11, 32'd15,       1'b0);
        send(5'd12, 32'h0000F0F0, 32'h0,        4'd12, 32'd8,        1'b0);
        send(5'd13, 32'h00008001, 32'h0,        4'd13, 32'hFFFF8001, 1'b0);
        send(5'd14, 32'h12340000, 32'hABCD0000, 4'd14, 32'hABCD1234, 1'b0);
        req_valid = 1'b0;
        drain(60);

        // illegal opcode between two XORs
        n0 = n_bmu;
        send(5'd4,  32'h0000F0F0, 32'h0000FF00, 4'd1, 32'h00000FF0, 1'b0);
        send(5'd20, 32'h12345678, 32'h9ABCDEF0, 4'd2, 32'h0,        1'b1);
        send(5'd4,  32'h1,        32'h3,        4'd3, 32'h2,        1'b0);
        req_valid = 1'b0;
        drain(30);
        chk("illegal_not_issued", 64'(n_bmu - n0), 64'(2));

        // response backpressure fills both FIFOs
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 5'd0; req_b = 32'd1; exp_err = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            req_a = 32'(100 + k); req_tag = TAG_W'(k); exp_res = 32'(101 + k);
            tick();
            if (acc_flag) k++;
        end
        req_valid = 1'b0;
        chk("bp_accepted", 64'(k), 64'(8));
        chk("bp_req_ready", 64'(req_ready), 64'(0));
        chk("bp_resp_valid", 64'(resp_valid), 64'(1));
        chk("bp_head_tag", 64'(resp_tag), 64'(0));
        chk("bp_busy", 64'(busy), 64'(1));
        tick();
        resp_ready = 1'b1;
        m = n_resp;
        drain(60);
        chk("bp_delivered", 64'(n_resp - m), 64'(8));

        // back-to-back GORC, good and bad shamt
        send(5'd15, 32'h00120000, 32'd7, 4'd5, 32'h00FF0000, 1'b0);
        send(5'd15, 32'h00120000, 32'd3, 4'd6, 32'h0,        1'b1);
        req_valid = 1'b0;
        drain(30);
        chk("gorc_consecutive", 64'(bmu_cyc_last - bmu_cyc_prev), 64'(1));

        // reset with ops in flight
        send(5'd0, 32'd1, 32'd1, 4'd7, 32'd2, 1'b0);
        send(5'd0, 32'd2, 32'd2, 4'd8, 32'd4, 1'b0);
        send(5'd0, 32'd3, 32'd3, 4'd9, 32'd6, 1'b0);
        req_valid = 1'b0;
        rst_l = 1'b0;
        tick();
        chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        sb_q.delete();
        iss_q.delete();
        hold_v = 1'b0;
        rst_l = 1'b1;
        tick();
        chk("midrst_req_ready_after", 64'(req_ready), 64'(1));
        repeat (8) tick();
        chk("midrst_no_stale", 64'(resp_valid), 64'(0));
        chk("midrst_idle", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
